// File: rtl/uart_baud_gen_if.sv
// Control/status bundle for the UART baud-tick generator: divisor programming,
// bit-phase resync and the three tick outputs.
interface uart_baud_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              i_en;
  logic [DIV_W-1:0]  i_div_int;
  logic [FRAC_W-1:0] i_div_frac;
  logic              i_div_load;
  logic              i_bit_sync;
  logic              o_div_pend;
  logic              o_tick_os;
  logic              o_tick_mid;
  logic              o_tick_bit;

  modport master (
    output i_en, i_div_int, i_div_frac, i_div_load, i_bit_sync,
    input  o_div_pend, o_tick_os, o_tick_mid, o_tick_bit
  );

  modport slave (
    input  i_en, i_div_int, i_div_frac, i_div_load, i_bit_sync,
    output o_div_pend, o_tick_os, o_tick_mid, o_tick_bit
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional-N UART baud-tick generator: oversample, mid-bit and end-of-bit ticks,
// with a shadowed divisor that switches only on a period boundary.
module uart_baud_gen #(
  parameter int CLK_HZ     = 125000000,
  parameter int DEF_BAUD   = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input logic            i_clk,
  input logic            i_rst,
  uart_baud_gen_if.slave bus
);
  localparam int     SUB_W   = $clog2(OVERSAMPLE);
  localparam longint BAUD_OS = longint'(DEF_BAUD) * longint'(OVERSAMPLE);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(longint'(CLK_HZ) / BAUD_OS);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'((longint'(CLK_HZ) <<< FRAC_W) / BAUD_OS);
  localparam logic [SUB_W-1:0]  SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [SUB_W-1:0]  sub;
  logic [DIV_W-1:0]  act_int, sh_int;
  logic [FRAC_W-1:0] act_frac, sh_frac;
  logic              pend;

  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W:0]    period_m1;
  logic [DIV_W-1:0]  ld_int;
  logic              tick_os;
  logic              apply_sh;

  // The fractional carry stretches this period by one cycle.
  assign acc_sum   = {1'b0, acc} + {1'b0, act_frac};
  assign period_m1 = {1'b0, act_int} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]} - 1'b1;
  assign tick_os   = bus.i_en & ({1'b0, cnt} == period_m1) & ~bus.i_bit_sync;
  assign ld_int    = (bus.i_div_int < DIV_W'(2)) ? DIV_W'(2) : bus.i_div_int;
  // A pending divisor lands on a period boundary, or at once while frozen.
  assign apply_sh  = pend & (tick_os | ~bus.i_en);

  assign bus.o_tick_os  = tick_os;
  assign bus.o_tick_mid = tick_os & (sub == SUB_MID);
  assign bus.o_tick_bit = tick_os & (sub == SUB_LAST);
  assign bus.o_div_pend = pend;

  // NOTE: all state updates use non-blocking assignments so every term below
  // reads the pre-edge register values, matching the combinational decode above.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt      <= '0;
      acc      <= '0;
      sub      <= '0;
      act_int  <= DEF_INT;
      act_frac <= DEF_FRAC;
      sh_int   <= DEF_INT;
      sh_frac  <= DEF_FRAC;
      pend     <= 1'b0;
    end else if (bus.i_bit_sync) begin
      cnt  <= '0;
      acc  <= '0;
      sub  <= '0;
      pend <= 1'b0;
      if (bus.i_div_load) begin
        act_int  <= ld_int;
        act_frac <= bus.i_div_frac;
        sh_int   <= ld_int;
        sh_frac  <= bus.i_div_frac;
      end else begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end
    end else begin
      if (tick_os) begin
        cnt <= '0;
        acc <= acc_sum[FRAC_W-1:0];
        sub <= sub + 1'b1;
      end else if (bus.i_en) begin
        cnt <= cnt + 1'b1;
      end
      if (apply_sh) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end
      pend <= bus.i_div_load | (pend & ~apply_sh);
      if (bus.i_div_load) begin
        sh_int  <= ld_int;
        sh_frac <= bus.i_div_frac;
      end
    end
  end
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed sequences, a divisor table and a random run,
// all shadowed cycle-by-cycle by an arithmetic model of tick timing.
module tb_uart_baud_gen;
  localparam int OS    = 16;
  localparam int SCALE = 16;

  logic i_clk;
  logic i_rst;
  uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4)) bus ();

  uart_baud_gen #(
    .CLK_HZ(125000000), .DEF_BAUD(115200), .OVERSAMPLE(OS), .DIV_W(16), .FRAC_W(4)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    int div_int;
    int div_frac;
    int p0, p1, p2, p3;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Model: active/shadow divisor, fractional residue, enabled cycles since the
  // last tick, and ticks since the bit origin.
  int m_int, m_frac, m_sh_int, m_sh_frac, m_res, m_elapsed, m_nos;
  bit m_pend;
  logic s_os, s_mid, s_bit, s_pend;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  task automatic step();
    int  period, ld_i, ld_f;
    bit  e_os, e_mid, e_bit, apply;
    #1;
    s_os   = bus.o_tick_os;
    s_mid  = bus.o_tick_mid;
    s_bit  = bus.o_tick_bit;
    s_pend = bus.o_div_pend;
    if (i_rst) begin
      m_int = 67; m_frac = 13; m_sh_int = 67; m_sh_frac = 13;
      m_res = 0; m_elapsed = 0; m_nos = 0; m_pend = 0;
    end else begin
      period = (m_res + m_int * SCALE + m_frac) / SCALE;
      e_os   = bus.i_en && !bus.i_bit_sync && (m_elapsed + 1 == period);
      e_mid  = e_os && (m_nos == OS / 2 - 1);
      e_bit  = e_os && (m_nos == OS - 1);
      check("cycle_model", {s_os, s_mid, s_bit, s_pend}, {e_os, e_mid, e_bit, m_pend});
      ld_i = (int'(bus.i_div_int) < 2) ? 2 : int'(bus.i_div_int);
      ld_f = int'(bus.i_div_frac);
      if (bus.i_bit_sync) begin
        if (bus.i_div_load) begin
          m_int = ld_i; m_frac = ld_f; m_sh_int = ld_i; m_sh_frac = ld_f;
        end else begin
          m_int = m_sh_int; m_frac = m_sh_frac;
        end
        m_pend = 0; m_res = 0; m_elapsed = 0; m_nos = 0;
      end else begin
        apply = m_pend && (e_os || !bus.i_en);
        if (e_os) begin
          m_elapsed = 0;
          m_res     = (m_res + m_frac) % SCALE;
          m_nos     = (m_nos + 1) % OS;
        end else if (bus.i_en) begin
          m_elapsed++;
        end
        if (apply) begin
          m_int = m_sh_int; m_frac = m_sh_frac;
        end
        m_pend = bus.i_div_load || (m_pend && !apply);
        if (bus.i_div_load) begin
          m_sh_int = ld_i; m_sh_frac = ld_f;
        end
      end
    end
    @(negedge i_clk);
  endtask

  // sel: 0 = oversample tick, 1 = mid tick, 2 = bit tick; n = cycles stepped.
  task automatic wait_ev(input int sel, output int n);
    n = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      n++;
      if ((sel == 0 && s_os === 1'b1) || (sel == 1 && s_mid === 1'b1) ||
          (sel == 2 && s_bit === 1'b1)) return;
    end
    check("wait_timeout", 0, 1);
    n = -1;
  endtask

  task automatic load(input int di, input int df, input bit sync);
    bus.i_div_int  = 16'(di);
    bus.i_div_frac = 4'(df);
    bus.i_div_load = 1'b1;
    bus.i_bit_sync = sync;
    step();
    bus.i_div_load = 1'b0;
    bus.i_bit_sync = 1'b0;
  endtask

  vec_t vecs[8];
  int   exps[4];
  int   n, n67, n68, sum, ticks;

  initial begin
    vecs[0] = '{10, 0, 10, 10, 10, 10};
    vecs[1] = '{0, 0, 2, 2, 2, 2};
    vecs[2] = '{1, 7, 2, 2, 3, 2};
    vecs[3] = '{3, 8, 3, 4, 3, 4};
    vecs[4] = '{5, 15, 5, 6, 6, 6};
    vecs[5] = '{2, 4, 2, 2, 2, 3};
    vecs[6] = '{67, 13, 67, 68, 68, 68};
    vecs[7] = '{300, 1, 300, 300, 300, 300};

    bus.i_en = 1'b1; bus.i_div_int = '0; bus.i_div_frac = '0;
    bus.i_div_load = 1'b0; bus.i_bit_sync = 1'b0;
    i_rst = 1'b1;
    step();
    step();
    check("reset_outputs", {s_os, s_mid, s_bit, s_pend}, 0);
    i_rst = 1'b0;

    // Default rate: 67.8125 cycles per oversample tick, 1085 per bit.
    wait_ev(0, n); check("first_os", n, 67);
    wait_ev(2, n); check("first_bit", n, 1085 - 67);
    n67 = 0; n68 = 0; sum = 0;
    for (int k = 0; k < OS; k++) begin
      wait_ev(0, n);
      sum += n;
      if (n == 67) n67++;
      if (n == 68) n68++;
    end
    check("bit_total", sum, 1085);
    check("count_67", n67, 3);
    check("count_68", n68, 13);

    // Mid-period load: the running 67-cycle period finishes untouched.
    for (int k = 0; k < 20; k++) step();
    load(10, 0, 1'b0);
    step(); check("pend_set", s_pend, 1);
    wait_ev(0, n); check("old_period_tail", n, 45);
    wait_ev(0, n); check("new_period", n, 10);
    check("pend_cleared", s_pend, 0);
    wait_ev(2, n);
    wait_ev(2, n); check("bit_spacing_160", n, 160);

    // Clamp of int 0 to 2, then int 3 frac 8 with residue 13 in the accumulator.
    load(0, 0, 1'b0);
    wait_ev(0, n); check("clamp_old_tail", n, 9);
    wait_ev(0, n); check("clamp_period", n, 2);
    load(3, 8, 1'b0);
    wait_ev(0, n); check("clamp_tail", n, 1);
    wait_ev(0, n); check("frac_p4a", n, 4);
    wait_ev(0, n); check("frac_p3", n, 3);
    wait_ev(0, n); check("frac_p4b", n, 4);

    // Resync: immediate divisor, then a sync on a would-be tick.
    load(10, 0, 1'b1);
    wait_ev(0, n); check("sync_first_os", n, 10);
    for (int k = 0; k < 9; k++) step();
    bus.i_bit_sync = 1'b1;
    step(); check("sync_masks_tick", s_os, 0);
    bus.i_bit_sync = 1'b0;
    wait_ev(1, n); check("sync_to_mid", n, 80);
    wait_ev(2, n); check("mid_to_bit", n, 80);

    // Freeze for 50 cycles mid-bit; remaining count is preserved.
    wait_ev(1, n); check("mid_again", n, 80);
    for (int k = 0; k < 3; k++) step();
    bus.i_en = 1'b0;
    ticks = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      ticks += int'(s_os) + int'(s_mid) + int'(s_bit);
    end
    check("frozen_ticks", ticks, 0);
    bus.i_en = 1'b1;
    wait_ev(2, n); check("resume_bit", n, 77);

    // Load while disabled becomes active one cycle after pend shows.
    bus.i_en = 1'b0;
    load(4, 0, 1'b0);
    step(); check("dis_pend_set", s_pend, 1);
    step(); check("dis_pend_clear", s_pend, 0);
    bus.i_en = 1'b1;
    wait_ev(0, n); check("dis_new_period", n, 4);

    // Reset with a pending load at sub = 9 discards it.
    for (int k = 0; k < 8; k++) wait_ev(0, n);
    load(20, 0, 1'b0);
    step(); check("pre_reset_pend", s_pend, 1);
    i_rst = 1'b1;
    step();
    step(); check("mid_reset_outputs", {s_os, s_mid, s_bit, s_pend}, 0);
    i_rst = 1'b0;
    wait_ev(0, n); check("default_resume", n, 67);
    check("resume_no_pend", s_pend, 0);

    // Divisor table, each entry loaded together with a resync.
    for (int v = 0; v < 8; v++) begin
      exps = '{vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3};
      load(vecs[v].div_int, vecs[v].div_frac, 1'b1);
      for (int k = 0; k < 4; k++) begin
        wait_ev(0, n);
        check($sformatf("vec%0d_p%0d", v, k), n, exps[k]);
      end
    end

    // Random run against the model.
    for (int i = 0; i < 2500; i++) begin
      bus.i_en       = ($urandom_range(0, 15) != 0);
      bus.i_div_load = ($urandom_range(0, 39) == 0);
      bus.i_div_int  = 16'($urandom_range(0, 12));
      bus.i_div_frac = 4'($urandom_range(0, 15));
      bus.i_bit_sync = ($urandom_range(0, 79) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
